scene_sequencer: RTL and testbench
==================================

Name: scene_sequencer

Overview:
- Frame-rate game-state controller for the layer compositor.
- Consumes one pulse per video frame plus player buttons.
- Generates every signed hoffset/voffset the logo, head and coin layers consume, and sequences the intro (countdown, logo slide-out, head rise) into the running phase.
- Tracks lane position, coin progression and score; sits between input conditioning and the layer chain.

Parameters:
- COUNTDOWN_FRAMES, 5, frames spent in COUNTDOWN before logo motion
- LOGO_STEP, 30, logo voffset increment per frame
- LOGO_END, 640, logo voffset at or above which slide-out is complete
- HEAD_START, 180, head voffset at reset
- HEAD_STEP, 17, head voffset decrement per frame
- HEAD_END, 50, head voffset at or below which rise is complete
- LANE_DX, 100, head hoffset distance between adjacent lanes
- LANE_STEP, 50, max head hoffset change per frame
- COIN_START, -50, coin progress value loaded on RUN entry and after each wrap
- COIN_END, 60, coin progress value that triggers a wrap
- HIT_POS, 50, coin progress value at which collection is evaluated

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, synchronous to clk
- btn_left  in  1  debounced level, synchronous to clk
- btn_right  in  1  debounced level, synchronous to clk
- restart  in  1  synchronous pulse; return to COUNTDOWN
- state  out  2  0=COUNTDOWN 1=LOGO 2=HEAD_RISE 3=RUN
- logo_voffset  out  12 signed  logo layer voffset
- head_hoffset  out  12 signed  head layer hoffset
- head_voffset  out  12 signed  head layer voffset
- coin_prog  out  12 signed  raw coin progress
- coin_hoffset  out  3x12 signed  {200-p, 280, 360+p}, p=max(coin_prog,0)
- coin_voffset  out  3x12 signed  40+6p, identical for all replicas
- coin_visible  out  3  coin_mask AND (coin_prog>=0)
- lane  out  2  0..2, centre=1
- score  out  8  collected coins, saturating

Behaviour:
- Reset (asynchronous, any time) and restart (synchronous, priority over frame_tick):
  - state=COUNTDOWN, countdown=COUNTDOWN_FRAMES, logo_voffset=0, head_voffset=HEAD_START, head_hoffset=0
  - lane=1, coin_prog=COIN_START, coin_mask=3'b111, score=0, pending flags cleared
  - restart does not need frame alignment
- Registered outputs only; coin_hoffset/coin_voffset combinational from registered coin_prog. All updates happen on the clk edge where frame_tick=1, except button edge capture.
- COUNTDOWN, on tick:
  - countdown>0: decrement
  - else: go to LOGO; no other change that tick
- LOGO, on tick:
  - logo_voffset<LOGO_END: add LOGO_STEP
  - else: go to HEAD_RISE
- HEAD_RISE, on tick:
  - head_voffset>HEAD_END: subtract HEAD_STEP
  - else: go to RUN, coin_prog=COIN_START
- RUN, on tick:
  - coin_prog<0: coin_prog=0
  - coin_prog==COIN_END: coin_prog=COIN_START, coin_mask rotated left by one; a mask of 000 reloads to 111
  - otherwise: coin_prog+1
- Buttons:
  - Rising edges captured every cycle, RUN only, into pend_l/pend_r sticky flags. Edges outside RUN are ignored and not captured.
  - Consumed on the next RUN tick:
    - pend_l only: lane = max(lane-1, 0)
    - pend_r only: lane = min(lane+1, 2)
    - both: no move
  - Flags clear on that tick in all three cases. An edge coinciding with the tick is held for the following tick.
- Head slew:
  - target = (lane-1)*LANE_DX
  - Each RUN tick, head_hoffset moves toward target by LANE_STEP, clamped to land exactly on target.
  - Uses the lane value before this tick's update (one-frame lag).
- Collection, evaluated on a RUN tick where coin_prog==HIT_POS before increment:
  - Condition: coin_mask[lane]=1 and head_hoffset==target.
  - Effect: score+1 (hold at 255), clear coin_mask[lane].
- Arithmetic: all offsets are 12-bit two's complement; no intermediate overflow is permitted for default parameters.

Test Plan:
- Assert rst mid-RUN with no clk edge -> all outputs at reset values immediately: state=0, head_voffset=180, coin_prog=-50, score=0.
- 5 ticks -> still COUNTDOWN; 6th tick -> state=1, logo_voffset=0; 22 further ticks -> logo_voffset=660; next tick -> state=2.
- HEAD_RISE: 8 ticks -> head_voffset 180->44; 9th tick -> state=3, coin_prog=-50; next tick -> coin_prog=0, coin_voffset=40, coin_hoffset={200,280,360}.
- RUN, pulse btn_right between ticks -> lane=2 after next tick; head_hoffset 0 then 50, 100 on following ticks. btn_left and btn_right edges in the same frame -> lane unchanged. btn_right edge during LOGO -> ignored.
- Lane=1 settled with coin_prog reaching 50 -> score=1, coin_visible[1]=0. At progress 60, next tick -> coin_prog=-50 and mask rotated.
- restart pulse in RUN with score=7 -> next cycle state=0, score=0, lane=1, logo_voffset=0.

Source files
------------

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-rate game-state controller for the layer compositor.
// Sequences countdown, logo slide-out and head rise into RUN; tracks lane, coins, score.
module scene_sequencer #(
    parameter int COUNTDOWN_FRAMES = 5,
    parameter int LOGO_STEP        = 30,
    parameter int LOGO_END         = 640,
    parameter int HEAD_START       = 180,
    parameter int HEAD_STEP        = 17,
    parameter int HEAD_END         = 50,
    parameter int LANE_DX          = 100,
    parameter int LANE_STEP        = 50,
    parameter int COIN_START       = -50,
    parameter int COIN_END         = 60,
    parameter int HIT_POS          = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    restart,
    output logic [1:0]              state,
    output logic signed [11:0]      logo_voffset,
    output logic signed [11:0]      head_hoffset,
    output logic signed [11:0]      head_voffset,
    output logic signed [11:0]      coin_prog,
    output logic [2:0][11:0]        coin_hoffset,
    output logic [2:0][11:0]        coin_voffset,
    output logic [2:0]              coin_visible,
    output logic [1:0]              lane,
    output logic [7:0]              score
);

    typedef enum logic [1:0] {
        S_COUNT = 2'd0,
        S_LOGO  = 2'd1,
        S_HEAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [15:0]        CNT_INIT = 16'(COUNTDOWN_FRAMES);
    localparam logic signed [11:0] LOGO_S   = 12'(LOGO_STEP);
    localparam logic signed [11:0] LOGO_E   = 12'(LOGO_END);
    localparam logic signed [11:0] HEAD_0   = 12'(HEAD_START);
    localparam logic signed [11:0] HEAD_S   = 12'(HEAD_STEP);
    localparam logic signed [11:0] HEAD_E   = 12'(HEAD_END);
    localparam logic signed [11:0] LDX      = 12'(LANE_DX);
    localparam logic signed [11:0] LSTEP    = 12'(LANE_STEP);
    localparam logic signed [11:0] COIN_0   = 12'(COIN_START);
    localparam logic signed [11:0] COIN_E   = 12'(COIN_END);
    localparam logic signed [11:0] HIT      = 12'(HIT_POS);

    state_t             st, st_nx;
    logic [15:0]        cnt, cnt_nx;
    logic signed [11:0] logo_nx, headh_nx, headv_nx, coin_nx;
    logic signed [11:0] target, diff, p;
    logic [2:0]         mask, mask_nx, lane_bit;
    logic [1:0]         lane_nx;
    logic [7:0]         score_nx;
    logic               pend_l, pend_r, pend_l_nx, pend_r_nx;
    logic               btn_l_q, btn_r_q, edge_l, edge_r, in_run;

    assign state        = st;
    assign in_run       = (st == S_RUN);
    assign edge_l       = btn_left & ~btn_l_q;
    assign edge_r       = btn_right & ~btn_r_q;
    assign lane_bit     = 3'b001 << lane;
    assign coin_visible = mask & {3{~coin_prog[11]}};
    assign diff         = target - head_hoffset;

    always_comb begin
        unique case (lane)
            2'd0:    target = -LDX;
            2'd2:    target = LDX;
            default: target = '0;
        endcase
    end

    // Coin replicas only start moving once progress is non-negative.
    always_comb begin
        p = coin_prog[11] ? 12'sd0 : coin_prog;
        coin_hoffset[2] = 12'sd200 - p;
        coin_hoffset[1] = 12'sd280;
        coin_hoffset[0] = 12'sd360 + p;
        for (int i = 0; i < 3; i++) begin
            coin_voffset[i] = 12'sd40 + p * 12'sd6;
        end
    end

    always_comb begin
        st_nx     = st;
        cnt_nx    = cnt;
        logo_nx   = logo_voffset;
        headh_nx  = head_hoffset;
        headv_nx  = head_voffset;
        coin_nx   = coin_prog;
        mask_nx   = mask;
        lane_nx   = lane;
        score_nx  = score;
        pend_l_nx = pend_l | (in_run & edge_l);
        pend_r_nx = pend_r | (in_run & edge_r);
        if (restart) begin
            st_nx     = S_COUNT;
            cnt_nx    = CNT_INIT;
            logo_nx   = '0;
            headh_nx  = '0;
            headv_nx  = HEAD_0;
            coin_nx   = COIN_0;
            mask_nx   = 3'b111;
            lane_nx   = 2'd1;
            score_nx  = '0;
            pend_l_nx = 1'b0;
            pend_r_nx = 1'b0;
        end else if (frame_tick) begin
            unique case (st)
                S_COUNT: begin
                    if (cnt != 16'd0) cnt_nx = cnt - 16'd1;
                    else              st_nx  = S_LOGO;
                end
                S_LOGO: begin
                    if (logo_voffset < LOGO_E) logo_nx = logo_voffset + LOGO_S;
                    else                       st_nx   = S_HEAD;
                end
                S_HEAD: begin
                    if (head_voffset > HEAD_E) begin
                        headv_nx = head_voffset - HEAD_S;
                    end else begin
                        st_nx   = S_RUN;
                        coin_nx = COIN_0;
                    end
                end
                S_RUN: begin
                    // Edges arriving on this very edge survive to the next tick.
                    pend_l_nx = edge_l;
                    pend_r_nx = edge_r;
                    if (pend_l && !pend_r && lane != 2'd0)
                        lane_nx = lane - 2'd1;
                    else if (pend_r && !pend_l && lane != 2'd2)
                        lane_nx = lane + 2'd1;
                    if (diff > LSTEP)       headh_nx = head_hoffset + LSTEP;
                    else if (diff < -LSTEP) headh_nx = head_hoffset - LSTEP;
                    else                    headh_nx = target;
                    if (coin_prog < 0) begin
                        coin_nx = '0;
                    end else if (coin_prog == COIN_E) begin
                        coin_nx = COIN_0;
                        mask_nx = (mask == 3'b000) ? 3'b111 : {mask[1:0], mask[2]};
                    end else begin
                        coin_nx = coin_prog + 12'sd1;
                    end
                    if (coin_prog == HIT && |(mask & lane_bit) &&
                        head_hoffset == target) begin
                        score_nx = (score == 8'hFF) ? score : score + 8'd1;
                        mask_nx  = mask & ~lane_bit;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= S_COUNT;
            cnt          <= CNT_INIT;
            logo_voffset <= '0;
            head_hoffset <= '0;
            head_voffset <= HEAD_0;
            coin_prog    <= COIN_0;
            mask         <= 3'b111;
            lane         <= 2'd1;
            score        <= '0;
            pend_l       <= 1'b0;
            pend_r       <= 1'b0;
            btn_l_q      <= 1'b0;
            btn_r_q      <= 1'b0;
        end else begin
            st           <= st_nx;
            cnt          <= cnt_nx;
            logo_voffset <= logo_nx;
            head_hoffset <= headh_nx;
            head_voffset <= headv_nx;
            coin_prog    <= coin_nx;
            mask         <= mask_nx;
            lane         <= lane_nx;
            score        <= score_nx;
            pend_l       <= pend_l_nx;
            pend_r       <= pend_r_nx;
            btn_l_q      <= btn_left;
            btn_r_q      <= btn_right;
        end
    end

endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed scoreboard bench for scene_sequencer.
// Expected values are queued with each stimulus step and checked after the frame edge.
module tb_scene_sequencer;

    logic              clk;
    logic              rst;
    logic              frame_tick;
    logic              btn_left;
    logic              btn_right;
    logic              restart;
    logic [1:0]        state;
    logic signed [11:0] logo_voffset;
    logic signed [11:0] head_hoffset;
    logic signed [11:0] head_voffset;
    logic signed [11:0] coin_prog;
    logic [2:0][11:0]  coin_hoffset;
    logic [2:0][11:0]  coin_voffset;
    logic [2:0]        coin_visible;
    logic [1:0]        lane;
    logic [7:0]        score;

    scene_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .restart      (restart),
        .state        (state),
        .logo_voffset (logo_voffset),
        .head_hoffset (head_hoffset),
        .head_voffset (head_voffset),
        .coin_prog    (coin_prog),
        .coin_hoffset (coin_hoffset),
        .coin_voffset (coin_voffset),
        .coin_visible (coin_visible),
        .lane         (lane),
        .score        (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        SIG_STATE, SIG_LOGO, SIG_HEADH, SIG_HEADV, SIG_COIN,
        SIG_CHOFF, SIG_CVOFF, SIG_VIS, SIG_LANE, SIG_SCORE
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [35:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    logic [2:0] rot_vis [3:7];
    logic [2:0] col_vis [3:7];

    function automatic logic [35:0] f12(input int v);
        logic [31:0] t;
        t = v;
        return {24'b0, t[11:0]};
    endfunction

    function automatic logic [35:0] observe(input sig_e s);
        case (s)
            SIG_STATE: return {34'b0, state};
            SIG_LOGO:  return {24'b0, logo_voffset};
            SIG_HEADH: return {24'b0, head_hoffset};
            SIG_HEADV: return {24'b0, head_voffset};
            SIG_COIN:  return {24'b0, coin_prog};
            SIG_CHOFF: return coin_hoffset;
            SIG_CVOFF: return coin_voffset;
            SIG_VIS:   return {33'b0, coin_visible};
            SIG_LANE:  return {34'b0, lane};
            SIG_SCORE: return {28'b0, score};
            default:   return '0;
        endcase
    endfunction

    task automatic push(input sig_e s, input logic [35:0] e, input string tag);
        exp_t x;
        x.sig = s;
        x.exp = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, observe(x.sig), x.exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        drain();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic l, input logic r);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        @(negedge clk);
        btn_left  = 1'b0;
        btn_right = 1'b0;
    endtask

    initial begin
        rot_vis[3] = 3'b010; col_vis[3] = 3'b000;
        rot_vis[4] = 3'b111; col_vis[4] = 3'b101;
        rot_vis[5] = 3'b011; col_vis[5] = 3'b001;
        rot_vis[6] = 3'b010; col_vis[6] = 3'b000;
        rot_vis[7] = 3'b111; col_vis[7] = 3'b101;

        rst = 1'b1; frame_tick = 1'b0; btn_left = 1'b0;
        btn_right = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(SIG_STATE, f12(0), "rst_state");
        push(SIG_LOGO, f12(0), "rst_logo");
        push(SIG_HEADV, f12(180), "rst_headv");
        push(SIG_HEADH, f12(0), "rst_headh");
        push(SIG_COIN, f12(-50), "rst_coin");
        push(SIG_LANE, f12(1), "rst_lane");
        push(SIG_SCORE, f12(0), "rst_score");
        push(SIG_VIS, f12(0), "rst_vis");
        drain();

        ticks(4);
        push(SIG_STATE, f12(0), "cd_5th_tick");
        tick();
        push(SIG_STATE, f12(1), "cd_to_logo");
        push(SIG_LOGO, f12(0), "logo_start");
        tick();

        pulse(1'b0, 1'b1);
        ticks(21);
        push(SIG_LOGO, f12(660), "logo_660");
        tick();
        push(SIG_STATE, f12(2), "logo_to_head");
        tick();

        ticks(7);
        push(SIG_HEADV, f12(44), "headv_44");
        tick();
        push(SIG_STATE, f12(3), "head_to_run");
        push(SIG_COIN, f12(-50), "run_coin_start");
        tick();
        push(SIG_COIN, f12(0), "coin_zero");
        push(SIG_CVOFF, {12'd40, 12'd40, 12'd40}, "cvoff_p0");
        push(SIG_CHOFF, {12'd200, 12'd280, 12'd360}, "choff_p0");
        push(SIG_VIS, f12(7), "vis_p0");
        push(SIG_LANE, f12(1), "logo_edge_ignored");
        tick();

        pulse(1'b1, 1'b1);
        push(SIG_LANE, f12(1), "both_btn_no_move");
        push(SIG_COIN, f12(1), "coin_1");
        tick();

        ticks(48);
        push(SIG_COIN, f12(50), "coin_50");
        tick();
        push(SIG_SCORE, f12(1), "collect_score1");
        push(SIG_VIS, f12(5), "collect_vis1");
        push(SIG_CHOFF, {12'd149, 12'd280, 12'd411}, "choff_p51");
        push(SIG_CVOFF, {12'd346, 12'd346, 12'd346}, "cvoff_p51");
        tick();
        ticks(8);
        push(SIG_COIN, f12(60), "coin_60");
        tick();
        push(SIG_COIN, f12(-50), "coin_wrap");
        push(SIG_VIS, f12(0), "vis_negative");
        tick();
        push(SIG_VIS, f12(3), "mask_rotated");
        tick();

        pulse(1'b0, 1'b1);
        push(SIG_LANE, f12(2), "lane_right");
        push(SIG_HEADH, f12(0), "slew_lag");
        tick();
        push(SIG_HEADH, f12(50), "slew_50");
        tick();
        push(SIG_HEADH, f12(100), "slew_100");
        tick();

        pulse(1'b1, 1'b0);
        push(SIG_LANE, f12(1), "lane_left");
        push(SIG_HEADH, f12(100), "slew_back_lag");
        tick();
        push(SIG_HEADH, f12(50), "slew_back_50");
        tick();
        push(SIG_HEADH, f12(0), "slew_back_0");
        tick();
        ticks(44);
        push(SIG_SCORE, f12(2), "collect_score2");
        push(SIG_VIS, f12(1), "collect_vis2");
        tick();
        ticks(10);

        for (int r = 3; r <= 7; r++) begin
            push(SIG_VIS, {33'b0, rot_vis[r]}, $sformatf("round%0d_mask", r));
            tick();
            ticks(50);
            push(SIG_SCORE, f12(r), $sformatf("round%0d_score", r));
            push(SIG_VIS, {33'b0, col_vis[r]}, $sformatf("round%0d_vis", r));
            tick();
            if (r < 7) ticks(10);
        end

        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        push(SIG_STATE, f12(0), "restart_state");
        push(SIG_SCORE, f12(0), "restart_score");
        push(SIG_LANE, f12(1), "restart_lane");
        push(SIG_LOGO, f12(0), "restart_logo");
        push(SIG_HEADV, f12(180), "restart_headv");
        push(SIG_HEADH, f12(0), "restart_headh");
        push(SIG_COIN, f12(-50), "restart_coin");
        drain();

        ticks(37);
        push(SIG_STATE, f12(3), "rerun_state");
        tick();
        ticks(3);

        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        push(SIG_STATE, f12(0), "async_state");
        push(SIG_HEADV, f12(180), "async_headv");
        push(SIG_COIN, f12(-50), "async_coin");
        push(SIG_SCORE, f12(0), "async_score");
        push(SIG_LANE, f12(1), "async_lane");
        push(SIG_LOGO, f12(0), "async_logo");
        drain();
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
